// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the program-memory loader: loader FSM states and memory geometry.
package inst_mem_loader_pkg;

    localparam int MEM_DEPTH  = 128;
    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DATA,
        CHECK
    } ld_state_e;

endpackage

// File: rtl/inst_mem_loader_ram_2r1w.sv
// 2^AW x DW array: one synchronous write port, two combinational read ports.
// Contents are not reset, so they survive a system reset.
module imem_ram_2r1w #(
    parameter int AW = 7,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr0_i,
    output logic [DW-1:0] rdata0_o,
    input  logic [AW-1:0] raddr1_i,
    output logic [DW-1:0] rdata1_o
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata0_o = mem[raddr0_i];
    assign rdata1_o = mem[raddr1_i];

endmodule

// File: rtl/inst_mem_loader.sv
// Program memory with a framed byte-stream loader: count byte, 4*N data bytes (MSB first),
// XOR check byte. The CPU is released from reset only after a frame whose checksum matches.
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int AW = $clog2(MEM_DEPTH)
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        load_start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        cpu_resetn,
    input  logic [31:0] a,
    output logic [31:0] inst,
    input  logic [31:0] rom_a,
    output logic [31:0] d_f_rom
);

    localparam int NMAX = 1 << AW;

    ld_state_e   state_q, state_d;
    logic [AW:0] ptr_q, ptr_d;
    logic [AW:0] nwords_q, nwords_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [23:0] shift_q, shift_d;
    logic [7:0]  csum_q, csum_d;
    logic        err_q, err_d;
    logic        done_q, done_d;
    logic        run_q, run_d;

    logic        accept;
    logic        we;
    logic [31:0] wdata;
    logic        unused_addr_bits;

    assign in_ready   = (state_q != IDLE);
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign err        = err_q;
    assign cpu_resetn = run_q;
    assign accept     = in_valid && in_ready;
    assign wdata      = {shift_q, in_data};

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        nwords_d = nwords_q;
        bcnt_d   = bcnt_q;
        shift_d  = shift_q;
        csum_d   = csum_q;
        err_d    = err_q;
        done_d   = 1'b0;
        run_d    = run_q;
        we       = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d = COUNT;
                    run_d   = 1'b0;
                    err_d   = 1'b0;
                    ptr_d   = '0;
                    bcnt_d  = '0;
                    csum_d  = '0;
                end
            end
            COUNT: begin
                if (accept) begin
                    if (32'(in_data) > NMAX) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end else begin
                        state_d  = DATA;
                        // A count of zero means a full-depth image.
                        nwords_d = (in_data == 8'd0) ? (AW+1)'(NMAX) : (AW+1)'(in_data);
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    csum_d = csum_q ^ in_data;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'(WORD_BYTES - 1)) begin
                        we    = 1'b1;
                        ptr_d = ptr_q + (AW+1)'(1);
                        // ptr is one bit wider than the index, so a full image ends at NMAX.
                        if (ptr_q + (AW+1)'(1) == nwords_q) begin
                            state_d = CHECK;
                        end
                    end else begin
                        shift_d = {shift_q[15:0], in_data};
                    end
                end
            end
            CHECK: begin
                if (accept) begin
                    state_d = IDLE;
                    if (csum_q == in_data) begin
                        done_d = 1'b1;
                        run_d  = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            nwords_q <= '0;
            bcnt_q   <= '0;
            shift_q  <= '0;
            csum_q   <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            nwords_q <= nwords_d;
            bcnt_q   <= bcnt_d;
            shift_q  <= shift_d;
            csum_q   <= csum_d;
            err_q    <= err_d;
            done_q   <= done_d;
            run_q    <= run_d;
        end
    end

    imem_ram_2r1w #(
        .AW (AW),
        .DW (32)
    ) u_ram (
        .clk_i    (clk),
        .we_i     (we),
        .waddr_i  (ptr_q[AW-1:0]),
        .wdata_i  (wdata),
        .raddr0_i (a[AW+1:2]),
        .rdata0_o (inst),
        .raddr1_i (rom_a[AW+1:2]),
        .rdata1_o (d_f_rom)
    );

    // Byte-lane and above-depth address bits are don't-care for word reads.
    assign unused_addr_bits = ^{a[31:AW+2], a[1:0], rom_a[31:AW+2], rom_a[1:0]};

endmodule

// File: doc/inst_mem_loader.md
# inst_mem_loader

Writable 128×32 instruction/data memory with a byte-stream loader. It is the write side of the program memory read by the CPU fetch port and the MIO data-read port. A host pushes a framed program image over a valid/ready byte interface. The block packs the bytes into words, writes them from word 0 upward, verifies a checksum, and releases the CPU from reset only after a good load. Read ports keep the existing combinational semantics, so the CPU and MIO see no change.

## Interface
- `AW`, default 7: word-address width; depth = 2^AW = 128 words.
- `clk`  in  1: system clock, rising edge.
- `clrn`  in  1: asynchronous active-low reset.
- `load_start`  in  1: one-cycle pulse; starts a frame when idle.
- `in_valid`  in  1: byte-stream valid.
- `in_data`  in  8: byte-stream data.
- `in_ready`  out  1: byte accepted on a cycle where `in_valid && in_ready`.
- `busy`  out  1: a frame is in progress.
- `done`  out  1: one-cycle pulse on a good frame.
- `err`  out  1: sticky error; cleared by the next `load_start`.
- `cpu_resetn`  out  1: low holds the CPU in reset; high after a good load.
- `a`  in  32: fetch byte address; index is `a[AW+1:2]`.
- `inst`  out  32: `mem[a[AW+1:2]]`, combinational.
- `rom_a`  in  32: data-read byte address; index is `rom_a[AW+1:2]`.
- `d_f_rom`  out  32: `mem[rom_a[AW+1:2]]`, combinational.

## Operation
- **Frame format:** count byte N, then 4·N data bytes, then one check byte.
  - N = 0 means 128 words. N > 128 is an error.
  - Each word is sent MSB first: byte0 → [31:24] … byte3 → [7:0].
  - Check byte = XOR of all 4·N data bytes. The count byte is excluded.
- **States:**
  - IDLE → COUNT on `load_start`.
  - COUNT → DATA when N is accepted and valid. COUNT → IDLE with `err`=1 when N > 128.
  - DATA → CHECK after the 4·N-th byte.
  - CHECK → IDLE when the check byte is accepted. On match: `done` pulse, `cpu_resetn`=1. On mismatch: `err`=1, `cpu_resetn` stays 0.
- **`in_ready`:** 1 in COUNT, DATA and CHECK; 0 in IDLE.
- **`busy`:** 1 in COUNT, DATA and CHECK.
- **`load_start` in IDLE:**
  - `cpu_resetn` drops to 0 on the next edge.
  - `err` clears on the next edge.
  - The word pointer and byte counter reset to 0.
  - The XOR accumulator resets to 0.
- **`load_start` while busy:** ignored.
- **Datapath in DATA:**
  - A 24-bit shift register holds bytes 0–2.
  - On the accepted byte3, `mem[ptr]` ← {shift, byte3} at that edge, and `ptr` increments.
  - The byte counter is 2 bits and wraps 3 → 0.
  - `ptr` is AW+1 bits, so N = 128 ends at `ptr` = 128 with no aliasing; the last write goes to index 127.
- **Words not covered by N** keep their previous contents. Memory has no reset; contents are undefined until written.
- **Reads are combinational.** A read of `mem[k]` reflects a write to k on the cycle after the write edge.
- **Reset, including mid-frame:**
  - State → IDLE, `busy`=0, `in_ready`=0, `done`=0, `err`=0, `cpu_resetn`=0.
  - Already-written words are retained.
  - The partial frame is abandoned; the host must restart with `load_start`.

## Timing
- Throughput: 1 byte per cycle with `in_valid` held high. A 128-word frame takes 514 accepted bytes.
- Latency: word write at the edge accepting its byte3. `done` and `cpu_resetn` change at the edge accepting the check byte.
- The handshake is AXI-style. The host must hold `in_data` stable while `in_valid`=1 and `in_ready`=0; the block never de-asserts `in_ready` mid-frame.
- Output reset values: `in_ready`=0, `busy`=0, `done`=0, `err`=0, `cpu_resetn`=0. `inst` and `d_f_rom` are undefined until written.

## Structure
- A shared package holds:
  - the state enum: IDLE, COUNT, DATA, CHECK;
  - `MEM_DEPTH`=128;
  - `WORD_BYTES`=4.
- One sub-module, `imem_ram_2r1w`: a 2^AW×32 array with one synchronous write port and two combinational read ports. It is reusable by the data memory.
- The FSM, shift register, counters and checksum live in the top module.

## Test plan
- **Good load:** N=3, words 0x2000_1D00, 0xDEAD_BEEF, 0x0000_0008, correct check byte → after the final byte: `done` pulse, `cpu_resetn`=1; `inst` at a=0/4/8 returns the three words; `d_f_rom` at rom_a=4 returns 0xDEAD_BEEF.
- **Bad checksum:** same frame, check byte XOR 0x01 → `err`=1, `cpu_resetn`=0, no `done`; the words are still written.
- **Full depth:** N=0 (128 words), word k = k → `mem[127]`=127 visible at a=0x1FC; `ptr` does not alias back to 0; `done` after 514 bytes.
- **Out-of-range count:** N=200 → `err`=1 the cycle after, `in_ready`=0, the following bytes are not consumed, memory is unchanged.
- **Backpressure and ignored restart:** random `in_valid` gaps plus a `load_start` pulse mid-DATA → identical memory image to the gap-free run; the restart pulse is ignored.
- **Reset mid-load:** assert `clrn` after 2 of 3 words → all outputs at reset values; words 0–1 retained; a subsequent full reload succeeds.
